// File: rtl/nes_pad_reader.sv
// NES gamepad reader: latches the pad, shifts in 8 active-low bits and presents a
// stable active-high button vector with a one-cycle valid strobe. Define PAD_EDGE_EN for the press output.
module nes_pad_reader #(
   parameter int HALF_CYCLES = 300,
   parameter int POLL_GAP    = 800000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       poll_req,
   input  logic       pad_data,
   output logic       pad_latch,
   output logic       pad_clk,
   output logic [7:0] buttons,
`ifdef PAD_EDGE_EN
   output logic [7:0] press,
`endif
   output logic       valid,
   output logic       busy
);
   // state  | meaning
   // IDLE   | waiting for gap expiry or poll_req
   // LATCH  | pad_latch high for two units
   // SETTLE | latch low one unit, bit 0 sampled at the end
   // CLK_HI | pad_clk high one unit
   // CLK_LO | pad_clk low one unit, bit [bit_idx] sampled at the end
   // DONE   | publish inverted shift data to buttons
   typedef enum logic [2:0] {IDLE, LATCH, SETTLE, CLK_HI, CLK_LO, DONE} state_t;

   localparam int UW = $clog2(2 * HALF_CYCLES);
   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [UW-1:0] UNIT_LEN  = UW'(HALF_CYCLES - 1);
   localparam logic [UW-1:0] LATCH_LEN = UW'(2 * HALF_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);

   state_t        state, state_nx;
   logic [UW-1:0] unit_cnt, unit_load;
   logic [GW-1:0] gap_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic [1:0]    sync;
   logic          unit_tc, sample_en;

   assign unit_tc = (unit_cnt == '0);

   always_comb begin
      state_nx  = state;
      unit_load = '0;
      sample_en = 1'b0;
      case (state)
         IDLE: begin
            if (poll_req || gap_cnt == GAP_LAST) begin
               state_nx  = LATCH;
               unit_load = LATCH_LEN;
            end
         end
         LATCH: begin
            if (unit_tc) begin
               state_nx  = SETTLE;
               unit_load = UNIT_LEN;
            end
         end
         SETTLE: begin
            if (unit_tc) begin
               state_nx  = CLK_HI;
               unit_load = UNIT_LEN;
               sample_en = 1'b1;
            end
         end
         CLK_HI: begin
            if (unit_tc) begin
               state_nx  = CLK_LO;
               unit_load = UNIT_LEN;
            end
         end
         CLK_LO: begin
            if (unit_tc) begin
               sample_en = 1'b1;
               if (bit_idx == 3'd7) begin
                  state_nx = DONE;
               end else begin
                  state_nx  = CLK_HI;
                  unit_load = UNIT_LEN;
               end
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         unit_cnt  <= '0;
         gap_cnt   <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         sync      <= 2'b11;
         pad_latch <= 1'b0;
         pad_clk   <= 1'b0;
         buttons   <= '0;
         valid     <= 1'b0;
         busy      <= 1'b0;
`ifdef PAD_EDGE_EN
         press     <= '0;
`endif
      end else begin
         state <= state_nx;
         sync  <= {sync[0], pad_data};

         if (state_nx != state)
            unit_cnt <= unit_load;
         else if (!unit_tc)
            unit_cnt <= unit_cnt - 1'b1;

         gap_cnt <= (state == IDLE && state_nx == IDLE) ? gap_cnt + 1'b1 : '0;

         // bit_idx wraps 7 -> 0 after the last bit, ready for the next SETTLE
         if (sample_en) begin
            shreg[bit_idx] <= sync[1];
            bit_idx        <= (state == SETTLE) ? 3'd1 : bit_idx + 3'd1;
         end

         pad_latch <= (state_nx == LATCH);
         pad_clk   <= (state_nx == CLK_HI);
         busy      <= (state_nx != IDLE);
         valid     <= (state == DONE);
         if (state == DONE)
            buttons <= ~shreg;
`ifdef PAD_EDGE_EN
         // buttons still holds the previous poll while in DONE
         press <= (state == DONE) ? (~shreg & ~buttons) : '0;
`endif
      end
   end
endmodule

// File: tb/tb_nes_pad_reader.sv
// Randomized bench for nes_pad_reader: behavioural pad shift register plus
// timing monitor; expected buttons come straight from the pad state at latch time.
module tb_nes_pad_reader;
   localparam int HC = 4;
   localparam int PG = 20;

   logic       clk_sys = 1'b0;
   logic       rst = 1'b1;
   logic       poll_req = 1'b0;
   logic       pad_data;
   logic       pad_latch, pad_clk, valid, busy;
   logic [7:0] buttons;
`ifdef PAD_EDGE_EN
   logic [7:0] press;
`endif

   nes_pad_reader #(.HALF_CYCLES(HC), .POLL_GAP(PG)) dut (
      .clk       (clk_sys),
      .rst       (rst),
      .poll_req  (poll_req),
      .pad_data  (pad_data),
      .pad_latch (pad_latch),
      .pad_clk   (pad_clk),
      .buttons   (buttons),
`ifdef PAD_EDGE_EN
      .press     (press),
`endif
      .valid     (valid),
      .busy      (busy)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // pad: 4021-style shift register, pressed=1 in pad_state, line is active-low
   logic [7:0] pad_state = 8'h00;
   logic [7:0] pad_sr = 8'h00;
   int         pad_mode = 0;   // 0 model, 1 line stuck high, 2 line stuck low

   always @(posedge pad_latch or posedge pad_clk)
      if (pad_latch) pad_sr = pad_state;
      else           pad_sr = {1'b0, pad_sr[7:1]};

   assign pad_data = (pad_mode == 1) ? 1'b1 : (pad_mode == 2) ? 1'b0 : ~pad_sr[0];

   int cyc;
   always @(posedge clk_sys or posedge rst)
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;

   int         latch_run, latch_len, latch_rise_cyc;
   int         pclk_run, pclk_pulses, pclk_bad;
   int         busy_run, busy_len;
   int         valid_cnt, valid_cyc, hold_bad, press_bad;
   logic [7:0] valid_buttons, valid_press, held;
   logic       prev_latch = 1'b0, prev_pclk = 1'b0, prev_busy = 1'b0;

   always @(negedge clk_sys) begin
      if (pad_latch === 1'b1 && prev_latch !== 1'b1) begin
         latch_rise_cyc = cyc;
         latch_run = 0;
      end
      if (pad_latch === 1'b1) latch_run++;
      if (pad_latch === 1'b0 && prev_latch === 1'b1) latch_len = latch_run;
      if (pad_clk === 1'b1 && prev_pclk !== 1'b1) begin
         pclk_pulses++;
         pclk_run = 0;
      end
      if (pad_clk === 1'b1) pclk_run++;
      if (pad_clk === 1'b0 && prev_pclk === 1'b1 && pclk_run != HC) pclk_bad++;
      if (busy === 1'b1 && prev_busy !== 1'b1) busy_run = 0;
      if (busy === 1'b1) busy_run++;
      if (busy === 1'b0 && prev_busy === 1'b1) busy_len = busy_run;
      if (valid === 1'b1) begin
         valid_cnt++;
         valid_cyc = cyc;
         valid_buttons = buttons;
         held = buttons;
      end else if (buttons !== held) begin
         hold_bad++;
      end
`ifdef PAD_EDGE_EN
      if (valid === 1'b1) valid_press = press;
      else if (press !== 8'h00) press_bad++;
`endif
      prev_latch = pad_latch;
      prev_pclk  = pad_clk;
      prev_busy  = busy;
   end

   logic [7:0] prev_exp;
   int         req_cyc;

   task automatic clear_stats();
      latch_len = 0; latch_rise_cyc = -100;
      pclk_pulses = 0; pclk_bad = 0;
      busy_len = 0; valid_cnt = 0; hold_bad = 0; press_bad = 0;
      valid_buttons = 8'hxx; valid_press = 8'hxx;
   endtask

   task automatic do_reset();
      @(posedge clk_sys); #2;
      rst = 1'b1;
      repeat (3) @(posedge clk_sys);
      #2;
      rst = 1'b0;
      clear_stats();
      held = 8'h00;
      prev_exp = 8'h00;
      valid_cyc = 0;
   endtask

   task automatic pulse_req();
      poll_req = 1'b1;
      @(posedge clk_sys); #2;
      poll_req = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (valid_cnt == 0 && n < 300) begin
         @(posedge clk_sys); #2;
         n++;
      end
      check("valid_seen", (valid_cnt != 0), 1);
   endtask

   // mode 0: auto poll right after reset, 1: auto poll after a poll, 2: poll_req
   task automatic run_poll(input int mode, input int delay, input logic [7:0] exp);
      int last_valid = valid_cyc;
      clear_stats();
      if (mode == 2) begin
         repeat (delay) @(posedge clk_sys);
         #2;
         req_cyc = cyc;
         pulse_req();
         repeat (8) @(posedge clk_sys);
         #2;
         pulse_req();   // while busy: must be dropped
      end
      wait_valid();
      case (mode)
         0:       check("first_latch_cycle", latch_rise_cyc, PG);
         1:       check("auto_gap", latch_rise_cyc - last_valid, PG);
         default: check("req_latency", latch_rise_cyc - req_cyc, 1);
      endcase
      check("latch_width", latch_len, 2 * HC);
      check("pclk_pulses", pclk_pulses, 7);
      check("pclk_width_bad", pclk_bad, 0);
      check("busy_len", busy_len, 17 * HC + 1);
      check("buttons", valid_buttons, exp);
      check("buttons_hold", hold_bad, 0);
`ifdef PAD_EDGE_EN
      check("press", valid_press, exp & ~prev_exp);
      check("press_idle_zero", press_bad, 0);
`endif
      prev_exp = exp;
      repeat (6) @(posedge clk_sys);
      #2;
      check("single_valid", valid_cnt, 1);
      check("idle_after_poll", busy, 0);
   endtask

   initial begin
      logic [7:0] r;
      int         n;
      do_reset();
      check("reset_outputs", {pad_latch, pad_clk, valid, busy, buttons}, 0);

      pad_state = 8'h09;
      run_poll(0, 0, 8'h09);
      pad_state = 8'h90;
      run_poll(1, 0, 8'h90);
      r = 8'($urandom);
      pad_state = r;
      run_poll(2, 3, r);

      for (int i = 0; i < 6; i++) begin
         r = 8'($urandom);
         pad_state = r;
         run_poll(int'($urandom_range(1, 2)), int'($urandom_range(0, 8)), r);
      end

      pad_mode = 1;
      run_poll(2, 2, 8'h00);
      pad_mode = 2;
      run_poll(2, 2, 8'hFF);
      pad_mode = 0;

      // abort in the CLK_HI phase of bit 4
      r = 8'($urandom);
      pad_state = r;
      clear_stats();
      pulse_req();
      n = 0;
      while (!(pclk_pulses == 4 && pad_clk === 1'b1) && n < 200) begin
         @(posedge clk_sys); #2;
         n++;
      end
      check("reached_bit4", (n < 200), 1);
      rst = 1'b1;
      #1;
      check("abort_outputs", {pad_latch, pad_clk, valid, busy, buttons}, 0);
      repeat (3) @(posedge clk_sys);
      #2;
      check("abort_no_valid", valid_cnt, 0);
      rst = 1'b0;
      clear_stats();
      held = 8'h00;
      prev_exp = 8'h00;
      run_poll(0, 0, r);

      do_reset();
      pad_state = 8'h01;
      run_poll(2, 1, 8'h01);
      pad_state = 8'h03;
      run_poll(2, 1, 8'h03);
      pad_state = 8'h02;
      run_poll(2, 1, 8'h02);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Reads a NES-style gamepad through its serial shift-register interface (latch, clock and data) for the pong game logic.
- Polls the pad periodically or on request, shifts in 8 button bits, and presents a stable active-high button vector with a one-cycle valid strobe.
- Sits between the top-level I/O pins and the paddle/game-state logic.

Parameters:
- HALF_CYCLES, 300: clk cycles per pad-clock half period and per latch/settle unit (6 us at 50 MHz); legal range 4 or more.
- POLL_GAP, 800000: clk cycles spent in IDLE before an automatic poll starts (about 16 ms at 50 MHz); must be at least 1.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- poll_req  in  1  single-cycle request; starts a poll immediately if the FSM is in IDLE, ignored otherwise.
- pad_data  in  1  serial data from the pad; active-low (0 = pressed), asynchronous to clk.
- pad_latch  out  1  latch strobe to the pad.
- pad_clk  out  1  shift clock to the pad.
- buttons  out  8  pressed = 1; bit order 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- valid  out  1  one-cycle pulse when buttons has just been updated.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset is asynchronous, active-high. On reset:
  - pad_latch=0, pad_clk=0, buttons=0, valid=0, busy=0.
  - FSM goes to IDLE; all counters and the shift register clear.
  - Reset asserted mid-poll aborts the poll; buttons is not updated.
- pad_data passes through a 2-flop synchronizer. All sampling uses the synchronized value, so HALF_CYCLES >= 4 guarantees the sample reflects the pad state.
- A unit counter counts HALF_CYCLES clk cycles per state unit.
- FSM states:
  - IDLE: latch=0, pclk=0. A gap counter increments each cycle. Go to LATCH when the gap counter reaches POLL_GAP-1, or on poll_req, whichever comes first. Clear the gap counter on exit. After reset, the first automatic latch rises at cycle POLL_GAP.
  - LATCH: pad_latch=1 for 2*HALF_CYCLES cycles, then go to SETTLE.
  - SETTLE: latch=0 for HALF_CYCLES cycles. On the last cycle, sample bit 0, set bit index to 1, go to CLK_HI.
  - CLK_HI: pad_clk=1 for HALF_CYCLES cycles, then go to CLK_LO.
  - CLK_LO: pad_clk=0 for HALF_CYCLES cycles. On the last cycle, sample bit [index]. If index==7, go to DONE; else increment index and go to CLK_HI.
  - DONE: one cycle. buttons <= bitwise inverse of the shifted data; valid=1 in the following cycle (registered). Return to IDLE.
- Poll timing: from the first LATCH cycle to the DONE cycle is 17*HALF_CYCLES+1 cycles inclusive. Exactly 7 pad_clk pulses per poll.
- buttons holds its value between polls.
- poll_req asserted while busy is dropped, not queued. A poll_req and a gap expiry in the same IDLE cycle start a single poll.
- Pad disconnected (pad_data pulled high) yields buttons=0.
- All outputs are registered; no combinational path from pad_data to any output.

Optional Feature:
- Macro PAD_EDGE_EN.
- When defined:
  - Adds output port press (8 bits).
  - In the valid cycle, press = new buttons AND NOT previous buttons; press is 0 in all other cycles.
  - Reset clears press and the previous-buttons register.
  - The first poll after reset reports every pressed button as an edge.
- When undefined: no port press and no extra registers; behaviour is otherwise identical.

Test Plan:
- Reset then auto-poll (HALF_CYCLES=4, POLL_GAP=20; pad model holds data low on bits 0 and 3):
  - pad_latch rises at cycle 20 and stays high 8 cycles.
  - Exactly 7 pad_clk pulses, each 4 cycles high.
  - valid pulses once and buttons=8'h09.
  - busy is high for 69 cycles.
- Back-to-back polls: pad pattern changes to Up+Right → next poll gives buttons=8'h90. buttons holds 8'h09 until that valid pulse.
- poll_req in IDLE:
  - pad_latch rises 1 cycle after the request.
  - poll_req pulsed while busy → no extra poll; exactly one valid pulse.
- Reset asserted in CLK_HI of bit 4:
  - all outputs go to 0 immediately (asynchronously).
  - no valid pulse.
  - after release, the next latch rises 20 cycles later.
- pad_data held high → buttons=8'h00. pad_data held low → buttons=8'hFF.
- PAD_EDGE_EN: polls reading 8'h01, 8'h03, 8'h02 → press=8'h01, 8'h02, 8'h00 in the respective valid cycles, and 0 in every other cycle.
